seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//   Sequential shift-add unsigned multiplier; inverse datapath of the lab's sequential divider.
//   Same start/done handshake as the divider, so benches and top-levels can drive either unit.
//   One partial-product step per clock. Sits beside the divider in the arithmetic unit.
// PARAMETERS
//   WIDTH   8   operand width in bits; product is 2*WIDTH bits
// PORTS
//   clk           input   1          system clock, rising-edge
//   rst_n         input   1          synchronous, active-low reset
//   start         input   1          request; sampled only when idle
//   multiplicand  input   WIDTH      operand A, unsigned
//   multiplier    input   WIDTH      operand B, unsigned
//   product       output  2*WIDTH    A*B, valid from done until the next accepted start
//   busy          output  1          high while a multiply is in progress
//   done          output  1          one-cycle pulse: product is valid
// BEHAVIOUR
//   Reset: rst_n=0 at a clk edge -> state IDLE, product=0, busy=0, done=0, internal regs=0.
//     Reset wins over every other input. Reset mid-operation aborts the multiply; no done pulse.
//   FSM states: IDLE, CALC, FINISH.
//     IDLE -> CALC   : start=1 at the edge. Latch A into acc_a (2*WIDTH, zero-extended) and B into
//                      shreg_b. Clear the product accumulator. Clear count. busy=1 at the next cycle.
//     CALC           : each edge, if shreg_b[0] then accum += acc_a. Then acc_a <<= 1, shreg_b >>= 1,
//                      count++. After WIDTH steps (count==WIDTH-1 at the edge) -> FINISH.
//     FINISH -> IDLE : product <= accum, done=1 for exactly this cycle, busy=0.
//   Latency: start sampled at edge N -> done high in the cycle after edge N+WIDTH+1. The latency is
//     fixed, with no early exit for zero operands or when shreg_b empties.
//   Width rules: accum and acc_a are 2*WIDTH bits, so no overflow is possible.
//     count is $clog2(WIDTH)+1 bits.
//   product is registered. It holds its last value through IDLE and CALC.
//     It changes only in FINISH and on reset.
//   start while busy (CALC/FINISH): ignored. Operands are not re-sampled, so operand changes after
//     acceptance do not affect the result.
//   start held high continuously: a new operation is accepted in the first IDLE cycle after FINISH.
//     Back-to-back throughput is therefore WIDTH+2 cycles per result.
//   start and reset asserted in the same cycle: reset wins and start is dropped.
//   Zero operand(s): product=0, still the full latency, done still pulses.
// STRUCTURE
//   Shared package/header arith_pkg: FSM state encodings (ST_IDLE=2'd0, ST_CALC=2'd1,
//     ST_FINISH=2'd2) and the default WIDTH. The divider reuses the same encodings.
//   Single module, no sub-modules: one FSM always block plus one datapath always block.
//   No adder sub-module; the 2*WIDTH add is inline.
// TESTING (clk period 20, rst_n low for 2 cycles)
//   1. A=4, B=6, start 1 cycle -> busy next cycle; done pulse after 10 cycles; product=24;
//      done high exactly 1 cycle.
//   2. A=255, B=255 -> product=65025 (16'hFE01). Checks full-width carry.
//   3. A=15, B=1 -> 15; A=0, B=200 -> 0 with done at the same latency as the other cases.
//   4. Start a=20,b=5; at cycle 3 pulse start with A=9,B=9 and change inputs -> product=100,
//      only one done pulse.
//   5. Start A=12,B=12; drop rst_n at cycle 4 for 1 cycle -> product=0, busy=0, no done.
//      Then A=7,B=8 -> 56.
//   6. start held high, A=3,B=5 -> done every 10 cycles, product=15 each time;
//      product stable between pulses.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encodings and default operand
// width, common to the sequential multiplier and divider.
package arith_pkg;

  localparam int ARITH_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } arith_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier. One partial-product step per clock,
// fixed latency, start/done handshake shared with the sequential divider.
module seq_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  arith_state_e       state_q, state_d;
  logic [2*WIDTH-1:0] acc_a_q;    // shifted multiplicand
  logic [WIDTH-1:0]   shreg_b_q;  // multiplier, LSB consumed each step
  logic [2*WIDTH-1:0] accum_q;    // running partial-product sum
  logic [CNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0] product_q;
  logic               done_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE, so it is ignored while busy
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_CALC;
      ST_CALC:   if (count_q == LAST_STEP) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift-add during CALC, publish in FINISH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_a_q   <= '0;
      shreg_b_q <= '0;
      accum_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_a_q   <= {{WIDTH{1'b0}}, multiplicand};
            shreg_b_q <= multiplier;
            accum_q   <= '0;
            count_q   <= '0;
          end
        end
        ST_CALC: begin
          // No early exit when shreg_b empties: latency stays fixed
          if (shreg_b_q[0]) accum_q <= accum_q + acc_a_q;
          acc_a_q   <= acc_a_q << 1;
          shreg_b_q <= shreg_b_q >> 1;
          count_q   <= count_q + CNT_W'(1);
        end
        ST_FINISH: begin
          product_q <= accum_q;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: vector table plus hand-written sequences
// for overlapping start, mid-operation reset and continuous start.
module tb_seq_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] product;
  logic           busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(a), .multiplier(b),
    .product(product), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, wait for done, check product/latency/pulse width.
  task automatic do_mul(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [2*W-1:0] exp, input string tag);
    int cyc;
    logic seen;
    a = va; b = vb; start = 1'b1;
    tick();                       // accept edge
    start = 1'b0;
    chk({tag, " busy after accept"}, 32'(busy), 32'd1);
    cyc  = 1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      cyc++;
      if (done) begin seen = 1'b1; break; end
    end
    chk({tag, " done seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(W + 2));
    chk({tag, " product"}, 32'(product), 32'(exp));
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
    tick();
    chk({tag, " done width"}, 32'(done), 32'd0);
    chk({tag, " product hold"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int ndone;
    int last_t;
    logic [2*W-1:0] cap;

    vecs[0] = '{8'd4,   8'd6,   16'd24};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd15,  8'd1,   16'd15};
    vecs[3] = '{8'd0,   8'd200, 16'd0};
    vecs[4] = '{8'd200, 8'd0,   16'd0};
    vecs[5] = '{8'd1,   8'd255, 16'd255};
    vecs[6] = '{8'd128, 8'd2,   16'd256};
    vecs[7] = '{8'd170, 8'd85,  16'd14450};

    // Reset for two cycles, start asserted to confirm reset wins
    rst_n = 1'b0; start = 1'b1; a = 8'd9; b = 8'd9;
    tick(); tick();
    chk("reset product", 32'(product), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle after reset busy", 32'(busy), 32'd0);

    // Vector table
    foreach (vecs[i]) do_mul(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Start while busy is ignored, operand changes after accept do not matter
    a = 8'd20; b = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'd9; b = 8'd9; start = 1'b1;
    tick();
    start = 1'b0; a = 8'd1; b = 8'd1;
    ndone = 0; cap = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) begin ndone++; cap = product; end
    end
    chk("busy-start product", 32'(cap), 32'd100);
    chk("busy-start done count", 32'(ndone), 32'd1);

    // Reset mid-operation aborts with no done
    a = 8'd12; b = 8'd12; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort product", 32'(product), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort no done", 32'(ndone), 32'd0);
    do_mul(8'd7, 8'd8, 16'd56, "post-abort");

    // Start held high: one result every W+2 cycles, product stable between
    a = 8'd3; b = 8'd5; start = 1'b1;
    ndone = 0; last_t = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (done) begin
        ndone++;
        chk("stream product", 32'(product), 32'd15);
        if (ndone > 1) chk("stream interval", 32'(t - last_t), 32'(W + 2));
        else           chk("stream first latency", 32'(t), 32'(W + 2));
        last_t = t;
      end else if (ndone > 0) begin
        chk("stream product stable", 32'(product), 32'd15);
      end
    end
    start = 1'b0;
    chk("stream done count", 32'(ndone), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
